// File: rtl/hilo_unit_pkg.sv
// Shared decode constants, FSM state type and instruction decode for the HI/LO unit.
// The multiplier uses the same funct constants.
package hilo_unit_pkg;

  localparam logic [5:0] FN_MULTU    = 6'b011001;
  localparam logic [5:0] FN_MFHI     = 6'b010000;
  localparam logic [5:0] FN_MTHI     = 6'b010001;
  localparam logic [5:0] FN_MFLO     = 6'b010010;
  localparam logic [5:0] FN_MTLO     = 6'b010011;
  localparam logic [1:0] ALUOP_RTYPE = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  typedef struct packed {
    logic multu;
    logic mfhi;
    logic mthi;
    logic mflo;
    logic mtlo;
  } dec_t;

  // Only R-type instructions carry a meaningful funct field.
  function automatic dec_t decode(input logic [5:0] fn, input logic [1:0] op);
    dec_t d;
    d = '0;
    if (op == ALUOP_RTYPE) begin
      d.multu = (fn == FN_MULTU);
      d.mfhi  = (fn == FN_MFHI);
      d.mthi  = (fn == FN_MTHI);
      d.mflo  = (fn == FN_MFLO);
      d.mtlo  = (fn == FN_MTLO);
    end
    return d;
  endfunction

endpackage

// File: rtl/hilo_unit_if.sv
// EX-stage request and HI/LO status bundle between the pipeline and hilo_unit.
interface hilo_unit_if #(
  parameter int WIDTH = 32
);

  logic [5:0]         signal;
  logic [1:0]         ALUop;
  logic [WIDTH-1:0]   dataA;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               stall;
  logic               done;
  logic [WIDTH-1:0]   rd_data;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  modport master (
    output signal, ALUop, dataA, product,
    input  busy, stall, done, rd_data, hi, lo
  );

  modport slave (
    input  signal, ALUop, dataA, product,
    output busy, stall, done, rd_data, hi, lo
  );

endinterface

// File: rtl/hilo_unit_regs.sv
// HI/LO register pair with independent write enables and the MFHI/MFLO read mux.
module hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we_hi,
  input  logic             i_we_lo,
  input  logic [WIDTH-1:0] i_wd_hi,
  input  logic [WIDTH-1:0] i_wd_lo,
  input  logic             i_rd_hi,
  input  logic             i_rd_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (i_we_hi) r_hi <= i_wd_hi;
      if (i_we_lo) r_lo <= i_wd_lo;
    end
  end

  // NOTE: the default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    o_rd_data = '0;
    if (i_rd_hi)      o_rd_data = r_hi;
    else if (i_rd_lo) o_rd_data = r_lo;
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/hilo_unit.sv
// MULTU sequencer and HI/LO owner: counts the multiplier iterations, captures the product,
// serves MFHI/MFLO/MTHI/MTLO and stalls the pipeline while a multiply is in flight.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  hilo_unit_if.slave  bus
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  dec_t             w_dec;
  logic             w_busy;
  logic             w_start;
  logic             w_capture;
  logic             w_uses_hilo;
  logic             w_we_hi;
  logic             w_we_lo;
  logic [WIDTH-1:0] w_wd_hi;
  logic [WIDTH-1:0] w_wd_lo;

  assign w_dec       = decode(bus.signal, bus.ALUop);
  assign w_busy      = (r_state == MUL);
  assign w_start     = w_dec.multu & ~w_busy;
  assign w_capture   = w_busy & (r_cnt == CW'(1));
  assign w_uses_hilo = w_dec.multu | w_dec.mfhi | w_dec.mflo | w_dec.mthi | w_dec.mtlo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= MUL;
            r_cnt   <= CW'(MUL_CYCLES);
          end
        end
        MUL: begin
          r_cnt <= r_cnt - CW'(1);
          if (w_capture) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Moves to HI/LO are only honoured when idle; while busy they are stalled and re-presented.
  assign w_we_hi = w_capture | (w_dec.mthi & ~w_busy);
  assign w_we_lo = w_capture | (w_dec.mtlo & ~w_busy);
  assign w_wd_hi = w_capture ? bus.product[2*WIDTH-1:WIDTH] : bus.dataA;
  assign w_wd_lo = w_capture ? bus.product[WIDTH-1:0]       : bus.dataA;

  hilo_regs #(
    .WIDTH (WIDTH)
  ) u_regs (
    .clk       (clk),
    .rst       (rst),
    .i_we_hi   (w_we_hi),
    .i_we_lo   (w_we_lo),
    .i_wd_hi   (w_wd_hi),
    .i_wd_lo   (w_wd_lo),
    .i_rd_hi   (w_dec.mfhi),
    .i_rd_lo   (w_dec.mflo),
    .o_hi      (bus.hi),
    .o_lo      (bus.lo),
    .o_rd_data (bus.rd_data)
  );

  assign bus.busy  = w_busy;
  assign bus.done  = r_done;
  assign bus.stall = w_busy & w_uses_hilo;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed vector table, multi-cycle corner sequences,
// and a randomized run against an abstract countdown model of HI/LO.
module tb_hilo_unit;
  import hilo_unit_pkg::*;

  localparam int W  = 32;
  localparam int MC = 32;
  localparam logic [5:0] FN_NOP = 6'b000000;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  hilo_unit_if #(.WIDTH(W)) bus ();

  hilo_unit #(.WIDTH(W), .MUL_CYCLES(MC)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] fn, input logic [1:0] op,
                       input logic [31:0] a, input logic [63:0] p);
    bus.signal  = fn;
    bus.ALUop   = op;
    bus.dataA   = a;
    bus.product = p;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [5:0]  fn;
    logic [1:0]  op;
    logic [31:0] a;
    logic        exp_stall;
    logic [31:0] exp_rd;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  // Abstract reference: remaining multiply cycles plus the architectural HI/LO values.
  int          m_left;
  logic [31:0] m_hi, m_lo;
  logic        m_done;

  function automatic bit is_op(input logic [5:0] fn, input logic [1:0] op, input logic [5:0] want);
    return (op == 2'b11) && (fn == want);
  endfunction

  task automatic model_edge(input logic [5:0] fn, input logic [1:0] op,
                            input logic [31:0] a, input logic [63:0] p);
    m_done = 1'b0;
    if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_hi   = p[63:32];
        m_lo   = p[31:0];
        m_done = 1'b1;
      end
    end else if (is_op(fn, op, FN_MULTU)) m_left = MC;
    else if (is_op(fn, op, FN_MTHI))     m_hi = a;
    else if (is_op(fn, op, FN_MTLO))     m_lo = a;
  endtask

  initial begin
    vec_t vecs[8];
    int   busy_cnt, done_cnt, stall_cnt, diff;
    int   done_at[$];
    bit   accept_next;

    rst = 1'b1;
    drive(FN_NOP, 2'b00, '0, '0);
    repeat (2) @(negedge clk);
    check("rst_hi",    {32'h0, bus.hi},  64'h0);
    check("rst_lo",    {32'h0, bus.lo},  64'h0);
    check("rst_busy",  {63'h0, bus.busy}, 64'h0);
    check("rst_done",  {63'h0, bus.done}, 64'h0);
    check("rst_stall", {63'h0, bus.stall}, 64'h0);
    rst = 1'b0;
    tick();

    // Idle-time moves and reads; expected values are cumulative across rows.
    vecs[0] = '{"mthi",       FN_MTHI,   2'b11, 32'h12345678, 1'b0, 32'h0,        32'h12345678, 32'h0};
    vecs[1] = '{"mtlo",       FN_MTLO,   2'b11, 32'h9ABCDEF0, 1'b0, 32'h0,        32'h12345678, 32'h9ABCDEF0};
    vecs[2] = '{"mfhi",       FN_MFHI,   2'b11, 32'h0,        1'b0, 32'h12345678, 32'h12345678, 32'h9ABCDEF0};
    vecs[3] = '{"mflo",       FN_MFLO,   2'b11, 32'h0,        1'b0, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0};
    vecs[4] = '{"mthi_nonr",  FN_MTHI,   2'b00, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h12345678, 32'h9ABCDEF0};
    vecs[5] = '{"bad_funct",  6'b010100, 2'b11, 32'h0000DEAD, 1'b0, 32'h0,        32'h12345678, 32'h9ABCDEF0};
    vecs[6] = '{"mtlo_small", FN_MTLO,   2'b11, 32'h00000055, 1'b0, 32'h0,        32'h12345678, 32'h00000055};
    vecs[7] = '{"mflo_nonr",  FN_MFLO,   2'b10, 32'h0,        1'b0, 32'h0,        32'h12345678, 32'h00000055};
    foreach (vecs[i]) begin
      drive(vecs[i].fn, vecs[i].op, vecs[i].a, 64'h0);
      #1;
      check({vecs[i].name, "_stall"}, {63'h0, bus.stall}, {63'h0, vecs[i].exp_stall});
      check({vecs[i].name, "_rd"},    {32'h0, bus.rd_data}, {32'h0, vecs[i].exp_rd});
      tick();
      check({vecs[i].name, "_hi"},    {32'h0, bus.hi}, {32'h0, vecs[i].exp_hi});
      check({vecs[i].name, "_lo"},    {32'h0, bus.lo}, {32'h0, vecs[i].exp_lo});
    end

    // 7*9: busy for exactly MC cycles, single done pulse.
    drive(FN_MULTU, 2'b11, '0, 64'd63);
    tick();
    busy_cnt = int'(bus.busy);
    done_cnt = 0;
    drive(FN_NOP, 2'b00, '0, 64'd63);
    for (int i = 0; i < 40; i++) begin
      tick();
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.done);
    end
    check("mul63_busy_cycles", 64'(busy_cnt), 64'(MC));
    check("mul63_done_pulses", 64'(done_cnt), 64'd1);
    check("mul63_hi", {32'h0, bus.hi}, 64'h0);
    check("mul63_lo", {32'h0, bus.lo}, 64'h3F);

    // Wide product taken verbatim, then read back through MFLO.
    drive(FN_MULTU, 2'b11, '0, 64'hFFFFFFFE_00000001);
    tick();
    drive(FN_NOP, 2'b00, '0, 64'hFFFFFFFE_00000001);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) break;
    end
    check("wide_hi", {32'h0, bus.hi}, 64'hFFFFFFFE);
    check("wide_lo", {32'h0, bus.lo}, 64'h00000001);
    drive(FN_MFLO, 2'b11, '0, '0);
    #1;
    check("wide_mflo_rd", {32'h0, bus.rd_data}, 64'h00000001);
    tick();

    // MFHI three cycles into a multiply stalls through capture, then sees the new HI.
    drive(FN_MULTU, 2'b11, '0, 64'h0BADF00D_CAFEBABE);
    tick();
    drive(FN_NOP, 2'b00, '0, 64'h0BADF00D_CAFEBABE);
    tick();
    tick();
    drive(FN_MFHI, 2'b11, '0, 64'h0BADF00D_CAFEBABE);
    stall_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!bus.stall) break;
      stall_cnt++;
      tick();
    end
    check("mfhi_stall_cycles", 64'(stall_cnt), 64'(MC - 2));
    check("mfhi_after_stall_rd", {32'h0, bus.rd_data}, 64'h0BADF00D);
    tick();

    // Reset mid-multiply abandons it; no later capture; a new MULTU is accepted.
    drive(FN_MTHI, 2'b11, 32'hA5A5A5A5, '0);
    tick();
    drive(FN_MULTU, 2'b11, '0, 64'h11112222_33334444);
    tick();
    drive(FN_NOP, 2'b00, '0, 64'h11112222_33334444);
    repeat (9) tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_hi",   {32'h0, bus.hi},   64'h0);
    check("midrst_lo",   {32'h0, bus.lo},   64'h0);
    check("midrst_busy", {63'h0, bus.busy}, 64'h0);
    check("midrst_done", {63'h0, bus.done}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      done_cnt += int'(bus.done);
    end
    check("midrst_no_capture_done", 64'(done_cnt), 64'd0);
    check("midrst_no_capture_lo", {32'h0, bus.lo}, 64'h0);
    drive(FN_MULTU, 2'b11, '0, 64'h5);
    tick();
    check("midrst_new_accept", {63'h0, bus.busy}, 64'h1);
    drive(FN_NOP, 2'b00, '0, 64'h5);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) break;
    end
    tick();

    // Back-to-back MULTU: the second stalls, is accepted on the edge after capture.
    drive(FN_MULTU, 2'b11, '0, 64'h2);
    stall_cnt   = 0;
    accept_next = 1'b0;
    for (int i = 0; i < 80; i++) begin
      #1;
      stall_cnt += int'(bus.stall);
      tick();
      if (accept_next) begin
        check("b2b_second_accept", {63'h0, bus.busy}, 64'h1);
        drive(FN_NOP, 2'b00, '0, 64'h2);
        accept_next = 1'b0;
      end
      if (bus.done) begin
        done_at.push_back(i);
        if (done_at.size() == 1) accept_next = 1'b1;
      end
    end
    diff = (done_at.size() == 2) ? (done_at[1] - done_at[0]) : -1;
    check("b2b_stall_cycles", 64'(stall_cnt), 64'(MC));
    check("b2b_done_pulses", 64'(done_at.size()), 64'd2);
    check("b2b_done_spacing", 64'(diff), 64'(MC + 1));

    // Randomized run against the abstract model.
    do_reset();
    m_left = 0; m_hi = '0; m_lo = '0; m_done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic [5:0]  fn;
      logic [1:0]  op;
      logic [31:0] a;
      logic [63:0] p;
      logic        m_stall;
      logic [31:0] m_rd;
      case ($urandom_range(0, 9))
        0:       fn = FN_MULTU;
        1, 2:    fn = FN_MFHI;
        3, 4:    fn = FN_MFLO;
        5:       fn = FN_MTHI;
        6:       fn = FN_MTLO;
        default: fn = 6'($urandom);
      endcase
      op = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
      a  = $urandom;
      p  = {$urandom, $urandom};
      drive(fn, op, a, p);
      m_stall = (m_left > 0) && (op == 2'b11) &&
                (fn inside {FN_MULTU, FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO});
      m_rd = is_op(fn, op, FN_MFHI) ? m_hi : (is_op(fn, op, FN_MFLO) ? m_lo : 32'h0);
      #1;
      check("rand_stall", {63'h0, bus.stall},   {63'h0, m_stall});
      check("rand_rd",    {32'h0, bus.rd_data}, {32'h0, m_rd});
      model_edge(fn, op, a, p);
      tick();
      check("rand_busy", {63'h0, bus.busy}, {63'h0, (m_left > 0)});
      check("rand_done", {63'h0, bus.done}, {63'h0, m_done});
      check("rand_hi",   {32'h0, bus.hi},   {32'h0, m_hi});
      check("rand_lo",   {32'h0, bus.lo},   {32'h0, m_lo});
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
